// File: rtl/interboard_pkg.sv
// Shared definitions for the inter-board link: message types, field widths and
// frame geometry. Used by both the transmitter and the receiver.
package interboard_pkg;

    localparam int BEAT_W      = 7;
    localparam int PAYLOAD_W   = 6;
    localparam int FRAME_BEATS = 4;
    localparam int BEAT_CNT_W  = 2;
    localparam int TIMEOUT_W   = 20;

    localparam int MSG_TYPE_W  = 4;
    localparam int BLOCK_X_W   = 5;
    localparam int BLOCK_Y_W   = 3;
    localparam int CARD_W      = 6;
    localparam int SEL_LEN_W   = 3;

    localparam logic [MSG_TYPE_W-1:0] TABLE_TAKE     = 4'd0;
    localparam logic [MSG_TYPE_W-1:0] TABLE_PUT      = 4'd1;
    localparam logic [MSG_TYPE_W-1:0] TABLE_SHIFT    = 4'd2;
    localparam logic [MSG_TYPE_W-1:0] TABLE_SELECT   = 4'd3;
    localparam logic [MSG_TYPE_W-1:0] TABLE_MOVE     = 4'd4;
    localparam logic [MSG_TYPE_W-1:0] DECK_DRAW      = 4'd5;
    localparam logic [MSG_TYPE_W-1:0] DECK_DISCARD   = 4'd6;
    localparam logic [MSG_TYPE_W-1:0] STATE_PASS     = 4'd7;
    localparam logic [MSG_TYPE_W-1:0] STATE_CHEAT    = 4'd8;
    localparam logic [MSG_TYPE_W-1:0] STATE_RST_GAME = 4'd9;

    // Anything above the game-reset code is not a defined message.
    function automatic logic is_defined_type(input logic [MSG_TYPE_W-1:0] t);
        return t <= STATE_RST_GAME;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous control bit.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Shift the asynchronous input through two flops to settle metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/interboard_rx.sv
// Inter-board frame receiver: 4-phase handshake, 4-beat frame assembly,
// frame checking and inter-beat timeout.
// Optional feature: define INTERBOARD_RX_PARITY_EN to enable even-parity
// checking of each frame; otherwise the parity bit is ignored.
module interboard_rx
    import interboard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_req,
    input  logic [BEAT_W-1:0]     rx_data,
    output logic                  rx_ack,
    output logic                  interboard_en,
    output logic                  interboard_rst,
    output logic [MSG_TYPE_W-1:0] interboard_msg_type,
    output logic [BLOCK_X_W-1:0]  interboard_block_x,
    output logic [BLOCK_Y_W-1:0]  interboard_block_y,
    output logic [CARD_W-1:0]     interboard_card,
    output logic [SEL_LEN_W-1:0]  interboard_sel_len,
    output logic                  interboard_move_dir,
    output logic                  rx_err
);

    typedef enum logic {
        ST_WAIT_REQ = 1'b0,
        ST_WAIT_REL = 1'b1
    } rx_state_e;

    rx_state_e              r_state;
    rx_state_e              w_state_nxt;
    logic                   w_req_sync;
    logic                   w_beat;
    logic [BEAT_CNT_W-1:0]  r_beat_cnt;
    logic [TIMEOUT_W-1:0]   r_to_cnt;
    logic [PAYLOAD_W-1:0]   r_b0;
    logic [PAYLOAD_W-1:0]   r_b1;
    logic [PAYLOAD_W-1:0]   r_b2;

    logic                   w_sof;
    logic [PAYLOAD_W-1:0]   w_pay;
    logic                   w_last;
    logic                   w_timeout;
    logic [MSG_TYPE_W-1:0]  w_type;
    logic                   w_par_ok;
    logic                   w_frame_bad;

    sync_2ff u_req_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx_req),
        .o_q (w_req_sync)
    );

    assign w_sof  = rx_data[BEAT_W-1];
    assign w_pay  = rx_data[PAYLOAD_W-1:0];
    assign w_type = r_b0[5:2];

    // Beat3 is the one that completes a frame; an SOF beat always restarts.
    assign w_last = w_beat && !w_sof && (r_beat_cnt == 2'd3);

    assign w_timeout = (r_beat_cnt != '0) && !w_beat &&
                       (r_to_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

`ifdef INTERBOARD_RX_PARITY_EN
    // Even parity across the 22 payload bits plus the parity bit itself.
    assign w_par_ok = ~^{r_b0, r_b1, r_b2, w_pay[5:1]};
`else
    logic w_unused_par;
    assign w_par_ok     = 1'b1;
    assign w_unused_par = w_pay[1];
`endif

    assign w_frame_bad = !is_defined_type(w_type) || w_pay[0] || !w_par_ok;

    // Handshake state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_WAIT_REQ;
        else     r_state <= w_state_nxt;
    end

    // Handshake next-state, acknowledge and beat-accept strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_beat      = 1'b0;
        rx_ack      = 1'b0;
        case (r_state)
            ST_WAIT_REQ: begin
                if (w_req_sync) begin
                    w_state_nxt = ST_WAIT_REL;
                    w_beat      = 1'b1;
                end
            end
            ST_WAIT_REL: begin
                rx_ack = 1'b1;
                if (!w_req_sync) w_state_nxt = ST_WAIT_REQ;
            end
            default: w_state_nxt = ST_WAIT_REQ;
        endcase
    end

    // Beat position and inter-beat timeout; an SOF beat always becomes beat0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt <= '0;
            r_to_cnt   <= '0;
        end else if (w_beat) begin
            r_to_cnt <= '0;
            if (w_sof)                  r_beat_cnt <= 2'd1;
            else if (r_beat_cnt != '0)  r_beat_cnt <= r_beat_cnt + 2'd1;
        end else if (r_beat_cnt != '0) begin
            if (w_timeout) begin
                r_beat_cnt <= '0;
                r_to_cnt   <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    // Hold the first three payloads until the frame completes.
    always_ff @(posedge clk) begin
        if (w_beat) begin
            if (w_sof) begin
                r_b0 <= w_pay;
            end else begin
                case (r_beat_cnt)
                    2'd1:    r_b1 <= w_pay;
                    2'd2:    r_b2 <= w_pay;
                    default: ;
                endcase
            end
        end
    end

    // Frame verdict pulses and decoded field update on beat3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            interboard_en       <= 1'b0;
            interboard_rst      <= 1'b0;
            rx_err              <= 1'b0;
            interboard_msg_type <= '0;
            interboard_block_x  <= '0;
            interboard_block_y  <= '0;
            interboard_card     <= '0;
            interboard_sel_len  <= '0;
            interboard_move_dir <= 1'b0;
        end else begin
            interboard_en  <= 1'b0;
            interboard_rst <= 1'b0;
            rx_err         <= w_timeout;
            if (w_last) begin
                if (w_frame_bad) begin
                    rx_err <= 1'b1;
                end else if (w_type == STATE_RST_GAME) begin
                    interboard_rst <= 1'b1;
                end else begin
                    interboard_en       <= 1'b1;
                    interboard_msg_type <= w_type;
                    interboard_block_x  <= {r_b0[1:0], r_b1[5:3]};
                    interboard_block_y  <= r_b1[2:0];
                    interboard_card     <= r_b2;
                    interboard_sel_len  <= w_pay[5:3];
                    interboard_move_dir <= w_pay[2];
                end
            end
        end
    end

endmodule

// File: tb/tb_interboard_rx.sv
module tb_interboard_rx;
    import interboard_pkg::*;

    localparam int TO = 100;
`ifdef INTERBOARD_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_req;
    logic [6:0]  rx_data;
    logic        rx_ack, interboard_en, interboard_rst, rx_err, interboard_move_dir;
    logic [3:0]  interboard_msg_type;
    logic [4:0]  interboard_block_x;
    logic [2:0]  interboard_block_y;
    logic [5:0]  interboard_card;
    logic [2:0]  interboard_sel_len;

    interboard_rx #(.TIMEOUT_CYCLES(TO)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rx_req              (rx_req),
        .rx_data             (rx_data),
        .rx_ack              (rx_ack),
        .interboard_en       (interboard_en),
        .interboard_rst      (interboard_rst),
        .interboard_msg_type (interboard_msg_type),
        .interboard_block_x  (interboard_block_x),
        .interboard_block_y  (interboard_block_y),
        .interboard_card     (interboard_card),
        .interboard_sel_len  (interboard_sel_len),
        .interboard_move_dir (interboard_move_dir),
        .rx_err              (rx_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_ack_cyc = 0;
    int last_code = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // ---------------- reference model: frame assembler over a queue ----------
    logic [5:0] m_q[$];
    logic [3:0] m_type;
    logic [4:0] m_bx;
    logic [2:0] m_by;
    logic [5:0] m_card;
    logic [2:0] m_sel;
    logic       m_dir;
    int m_en_n = 0, m_rst_n = 0, m_err_n = 0;

    function automatic void model_reset();
        m_q.delete();
        m_type = 0; m_bx = 0; m_by = 0; m_card = 0; m_sel = 0; m_dir = 0;
    endfunction

    // Returns 0 none, 1 valid frame, 2 game reset, 3 dropped frame.
    function automatic int model_beat(input logic [6:0] b);
        logic [3:0]  ty;
        logic [22:0] bits;
        if (b[6]) begin
            m_q.delete();
            m_q.push_back(b[5:0]);
            return 0;
        end
        if (m_q.size() == 0) return 0;
        m_q.push_back(b[5:0]);
        if (m_q.size() < FRAME_BEATS) return 0;
        ty   = m_q[0][5:2];
        bits = {m_q[0], m_q[1], m_q[2], m_q[3][5:1]};
        if (ty >= 10 || m_q[3][0] || (PAR_EN && (^bits))) begin
            m_q.delete();
            m_err_n++;
            return 3;
        end
        if (ty == 9) begin
            m_q.delete();
            m_rst_n++;
            return 2;
        end
        m_type = ty;
        m_bx   = {m_q[0][1:0], m_q[1][5:3]};
        m_by   = m_q[1][2:0];
        m_card = m_q[2];
        m_sel  = m_q[3][5:3];
        m_dir  = m_q[3][2];
        m_q.delete();
        m_en_n++;
        return 1;
    endfunction

    function automatic logic [27:0] make_frame(input int ty, input int bx, input int by,
                                               input int cd, input int sl, input int dir,
                                               input int res, input int flip);
        logic [5:0] p0, p1, p2, p3;
        logic       par;
        p0 = {ty[3:0], bx[4:3]};
        p1 = {bx[2:0], by[2:0]};
        p2 = cd[5:0];
        p3 = {sl[2:0], dir[0], 1'b0, res[0]};
        par = ^{p0, p1, p2, p3[5:2]};
        if (flip != 0) par = ~par;
        p3[1] = par;
        return {1'b1, p0, 1'b0, p1, 1'b0, p2, 1'b0, p3};
    endfunction

    // ---------------- monitor: pulse counts, exclusivity, width, ack edges ----
    int dut_en_n = 0, dut_rst_n = 0, dut_err_n = 0, ack_rise = 0, viol = 0;
    logic [2:0] mon_p, mon_prev = 3'b0;
    logic       mon_prev_ack = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            mon_prev     = 3'b0;
            mon_prev_ack = 1'b0;
        end else begin
            mon_p = {interboard_en, interboard_rst, rx_err};
            dut_en_n  += int'(mon_p[2]);
            dut_rst_n += int'(mon_p[1]);
            dut_err_n += int'(mon_p[0]);
            if ($countones(mon_p) > 1 || (mon_p & mon_prev) != 3'b0) viol++;
            if (rx_ack && !mon_prev_ack) ack_rise++;
            mon_prev     = mon_p;
            mon_prev_ack = rx_ack;
        end
    end

    task automatic check_fields(input string tag);
        chk({tag, "_type"}, 32'(interboard_msg_type), 32'(m_type));
        chk({tag, "_bx"},   32'(interboard_block_x),  32'(m_bx));
        chk({tag, "_by"},   32'(interboard_block_y),  32'(m_by));
        chk({tag, "_card"}, 32'(interboard_card),     32'(m_card));
        chk({tag, "_sel"},  32'(interboard_sel_len),  32'(m_sel));
        chk({tag, "_dir"},  32'(interboard_move_dir), 32'(m_dir));
    endtask

    task automatic send_beat(input logic [6:0] b, input string tag);
        int code_exp, n;
        code_exp = model_beat(b);
        @(posedge clk); #2;
        rx_data = b;
        rx_req  = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!rx_ack && n < 20);
        chk({tag, "_ack_rise"}, 32'(rx_ack), 1);
        last_ack_cyc = cyc;
        last_code = interboard_en ? 1 : interboard_rst ? 2 : rx_err ? 3 : 0;
        chk({tag, "_pulse"}, last_code, code_exp);
        if (code_exp != 0) check_fields(tag);
        @(posedge clk); #2;
        rx_req  = 1'b0;
        rx_data = 7'($urandom);
        n = 0;
        do begin @(negedge clk); n++; end while (rx_ack && n < 20);
        chk({tag, "_ack_fall"}, 32'(rx_ack), 0);
    endtask

    task automatic send_frame(input logic [27:0] f, input int nbeats, input string tag);
        logic [6:0] b;
        for (int i = 0; i < nbeats; i++) begin
            b = f[27 - 7*i -: 7];
            send_beat(b, tag);
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, e0, t_err, n, r, nb;
        rst = 1'b1; rx_req = 1'b0; rx_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ack",    32'(rx_ack), 0);
        chk("reset_pulses", 32'({interboard_en, interboard_rst, rx_err}), 0);
        chk("reset_type",   32'(interboard_msg_type), 0);
        chk("reset_card",   32'(interboard_card), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Non-SOF beat with nothing in progress is acknowledged and ignored.
        send_beat(7'h15, "stray");

        // DECK_DRAW, card 37.
        a0 = ack_rise;
        send_frame(make_frame(5, 0, 0, 37, 0, 0, 0, 0), 4, "deck");
        chk("deck_acks", ack_rise - a0, 4);
        chk("deck_type", 32'(interboard_msg_type), 5);
        chk("deck_card", 32'(interboard_card), 37);

        // TABLE_SHIFT with block coordinates and direction.
        send_frame(make_frame(2, 17, 5, 12, 3, 1, 0, 0), 4, "shift");
        chk("shift_bx",  32'(interboard_block_x), 17);
        chk("shift_by",  32'(interboard_block_y), 5);
        chk("shift_dir", 32'(interboard_move_dir), 1);

        // Game reset: pulse only, fields retained.
        a0 = dut_en_n;
        send_frame(make_frame(9, 3, 1, 60, 7, 0, 0, 0), 4, "rstgame");
        chk("rstgame_last", last_code, 2);
        chk("rstgame_no_en", dut_en_n - a0, 0);
        chk("rstgame_keep_type", 32'(interboard_msg_type), 2);
        chk("rstgame_keep_bx",   32'(interboard_block_x), 17);

        // Partial frame superseded by a fresh SOF frame.
        e0 = dut_err_n;
        send_frame(make_frame(7, 30, 2, 1, 1, 1, 0, 0), 2, "partial");
        send_frame(make_frame(3, 9, 6, 44, 2, 0, 0, 0), 4, "resync");
        chk("resync_no_err", dut_err_n - e0, 0);
        chk("resync_type", 32'(interboard_msg_type), 3);

        // Inter-beat timeout after two beats.
        send_frame(make_frame(6, 1, 1, 2, 0, 0, 0, 0), 2, "tohead");
        t_err = -1;
        n = 0;
        while (n < 300 && t_err < 0) begin
            @(negedge clk);
            n++;
            if (rx_err) t_err = cyc;
        end
        chk("timeout_latency", t_err - last_ack_cyc, TO);
        m_q.delete();
        m_err_n++;
        send_frame(make_frame(8, 20, 4, 33, 5, 1, 0, 0), 4, "after_to");
        chk("after_to_type", 32'(interboard_msg_type), 8);

        // Flipped parity bit.
        send_frame(make_frame(4, 11, 3, 21, 6, 0, 0, 1), 4, "parflip");
        chk("parflip_verdict", last_code, PAR_EN ? 3 : 1);

        // Reset asserted while acknowledging: ack drops without a clock edge.
        @(posedge clk); #2;
        rx_data = 7'h55; rx_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!rx_ack && n < 20);
        chk("rel_ack_high", 32'(rx_ack), 1);
        #2 rst = 1'b1;
        #1;
        chk("rel_rst_ack", 32'(rx_ack), 0);
        chk("rel_rst_type", 32'(interboard_msg_type), 0);
        rx_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);

        // First honoured frame after reset must start with SOF.
        send_beat(7'h2A, "post_rst_stray");
        send_frame(make_frame(1, 5, 2, 9, 1, 0, 0, 0), 4, "post_rst");

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                send_beat({1'b0, 6'($urandom)}, "rnd_stray");
            end else begin
                nb = (r == 1) ? $urandom_range(1, 3) : 4;
                send_frame(make_frame($urandom_range(0, 15), $urandom_range(0, 31),
                                      $urandom_range(0, 7), $urandom_range(0, 63),
                                      $urandom_range(0, 7), $urandom_range(0, 1),
                                      ($urandom_range(0, 7) == 0) ? 1 : 0,
                                      ($urandom_range(0, 5) == 0) ? 1 : 0),
                           nb, "rnd");
            end
        end

        chk("total_en",  dut_en_n,  m_en_n);
        chk("total_rst", dut_rst_n, m_rst_n);
        chk("total_err", dut_err_n, m_err_n);
        chk("pulse_excl_width", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
